// File: rtl/float_to_integer_seq.sv
// float_to_integer_seq
// Iterative IEEE-754 single-precision to 32-bit two's-complement integer
// converter (truncation toward zero). The mantissa is aligned by a shift
// register that moves up to STEP bits per cycle; a start/busy/done handshake
// sequences each conversion. Flags report discarded fraction bits (p_lost)
// and NaN/Inf/out-of-range operands (invalid).
module float_to_integer_seq #(
  parameter int STEP = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] a,
  output logic        busy,
  output logic        done,
  output logic [31:0] d,
  output logic        p_lost,
  output logic        invalid
);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  localparam logic [4:0] STEP_W = 5'(STEP);

  state_t      state_q, state_d;
  logic [31:0] mag_q, mag_d;
  logic [4:0]  remain_q, remain_d;
  logic        left_q, left_d;
  logic        sign_q, sign_d;
  logic        sticky_q, sticky_d;
  logic        minInt_q, minInt_d;
  logic        badOp_q, badOp_d;
  logic        done_q, done_d;
  logic [31:0] res_q, res_d;
  logic        pLost_q, pLost_d;
  logic        invalid_q, invalid_d;

  logic [7:0]  expo;
  logic [31:0] mant;
  logic [4:0]  stepAmt;
  logic [31:0] lostMask;

  assign expo = a[30:23];
  assign mant = {8'd0, 1'b1, a[22:0]};

  // Next-state logic: classify the operand on acceptance, then shift the
  // magnitude toward its integer position and finally register the result.
  always_comb begin
    state_d   = state_q;
    mag_d     = mag_q;
    remain_d  = remain_q;
    left_d    = left_q;
    sign_d    = sign_q;
    sticky_d  = sticky_q;
    minInt_d  = minInt_q;
    badOp_d   = badOp_q;
    done_d    = 1'b0;
    res_d     = res_q;
    pLost_d   = pLost_q;
    invalid_d = invalid_q;

    stepAmt  = (remain_q < STEP_W) ? remain_q : STEP_W;
    lostMask = (32'd1 << stepAmt) - 32'd1;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = SHIFT;
          sign_d   = a[31];
          left_d   = 1'b0;
          minInt_d = 1'b0;
          badOp_d  = 1'b0;
          sticky_d = 1'b0;
          mag_d    = 32'd0;
          remain_d = 5'd0;
          if (expo == 8'd0) begin
            sticky_d = |a[22:0];
          end else if (expo <= 8'd126) begin
            sticky_d = 1'b1;
          end else if (expo <= 8'd149) begin
            mag_d    = mant;
            remain_d = 5'(8'd150 - expo);
          end else if (expo == 8'd150) begin
            mag_d = mant;
          end else if (expo <= 8'd157) begin
            mag_d    = mant;
            remain_d = 5'(expo - 8'd150);
            left_d   = 1'b1;
          end else if (a == 32'hCF00_0000) begin
            minInt_d = 1'b1;
          end else begin
            badOp_d = 1'b1;
          end
        end
      end
      SHIFT: begin
        if (remain_q != 5'd0) begin
          remain_d = remain_q - stepAmt;
          if (left_q) begin
            mag_d = mag_q << stepAmt;
          end else begin
            sticky_d = sticky_q | (|(mag_q & lostMask));
            mag_d    = mag_q >> stepAmt;
          end
        end else begin
          state_d = IDLE;
          done_d  = 1'b1;
          if (minInt_q || badOp_q) begin
            res_d   = 32'h8000_0000;
            pLost_d = 1'b0;
          end else begin
            res_d   = sign_q ? -mag_q : mag_q;
            pLost_d = sticky_q;
          end
          invalid_d = badOp_q;
        end
      end
    endcase
  end

  // State and datapath registers; reset aborts any conversion in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      mag_q     <= 32'd0;
      remain_q  <= 5'd0;
      left_q    <= 1'b0;
      sign_q    <= 1'b0;
      sticky_q  <= 1'b0;
      minInt_q  <= 1'b0;
      badOp_q   <= 1'b0;
      done_q    <= 1'b0;
      res_q     <= 32'd0;
      pLost_q   <= 1'b0;
      invalid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      mag_q     <= mag_d;
      remain_q  <= remain_d;
      left_q    <= left_d;
      sign_q    <= sign_d;
      sticky_q  <= sticky_d;
      minInt_q  <= minInt_d;
      badOp_q   <= badOp_d;
      done_q    <= done_d;
      res_q     <= res_d;
      pLost_q   <= pLost_d;
      invalid_q <= invalid_d;
    end
  end

  assign busy    = (state_q == SHIFT);
  assign done    = done_q;
  assign d       = res_q;
  assign p_lost  = pLost_q;
  assign invalid = invalid_q;

endmodule

// File: tb/tb_float_to_integer_seq.sv
// Testbench for float_to_integer_seq: directed operands, a float-to-int
// reference model, and a per-cycle compare process on the handshake outputs.
module tb_float_to_integer_seq;

  localparam int TB_STEP = 4;

  typedef struct {
    logic [31:0] d;
    logic        pLost;
    logic        inv;
    int          lat;
    int          acceptEdge;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        start;
  logic [31:0] a;
  logic        busy;
  logic        done;
  logic [31:0] d;
  logic        p_lost;
  logic        invalid;

  int          assertCount;
  int          failCount;
  int          cycleCount;
  bit          checkEn;
  logic [31:0] heldD;
  exp_t        expQ[$];

  float_to_integer_seq #(.STEP(TB_STEP)) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .a(a),
    .busy(busy),
    .done(done),
    .d(d),
    .p_lost(p_lost),
    .invalid(invalid)
  );

  // Free-running clock and an edge counter used to measure latency.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cycleCount = 0;
  always @(posedge clk) cycleCount++;

  // Reference: value = 1.m * 2^(e-127), truncated toward zero.
  function automatic exp_t model(input logic [31:0] x);
    exp_t   r;
    int     e;
    longint m;
    longint mag;
    int     sh;
    e   = int'(x[30:23]);
    m   = longint'({1'b1, x[22:0]});
    mag = 0;
    r.pLost = 1'b0;
    r.inv   = 1'b0;
    r.lat   = 1;
    r.acceptEdge = 0;
    if (e >= 158) begin
      r.inv = (x != 32'hCF00_0000);
      r.d   = 32'h8000_0000;
      return r;
    end else if (e == 0) begin
      r.pLost = (x[22:0] != 0);
    end else if (e < 127) begin
      r.pLost = 1'b1;
    end else if (e <= 150) begin
      sh  = 150 - e;
      mag = m / (64'd1 << sh);
      r.pLost = (m % (64'd1 << sh)) != 0;
      if (sh > 0) r.lat = (sh + TB_STEP - 1) / TB_STEP + 1;
    end else begin
      sh  = e - 150;
      mag = m * (64'd1 << sh);
      r.lat = (sh + TB_STEP - 1) / TB_STEP + 1;
    end
    r.d = x[31] ? 32'(-mag) : 32'(mag);
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // Per-cycle checker: handshake exclusivity, result on each done pulse,
  // and result held between pulses.
  always @(negedge clk) begin
    if (checkEn) begin
      checkOutput("busy_done_excl", 32'(busy & done), 32'd0);
      if (done) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpected_done", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = expQ.pop_front();
          checkOutput("d", d, e.d);
          checkOutput("p_lost", 32'(p_lost), 32'(e.pLost));
          checkOutput("invalid", 32'(invalid), 32'(e.inv));
          checkOutput("latency", 32'(cycleCount - e.acceptEdge), 32'(e.lat));
          heldD = e.d;
        end
      end else begin
        checkOutput("d_held", d, heldD);
      end
    end
  end

  // Issue one operand: wait for IDLE (or for the done pulse), then drive start.
  task automatic applyStimulus(input logic [31:0] x, input bit inDoneCycle);
    int   guard;
    exp_t e;
    guard = 0;
    @(negedge clk);
    while (inDoneCycle ? !done : busy) begin
      @(negedge clk);
      guard++;
      if (guard > 200) begin
        checkOutput("wait_timeout", 32'd1, 32'd0);
        return;
      end
    end
    start = 1'b1;
    a     = x;
    @(posedge clk);
    #1;
    start = 1'b0;
    e = model(x);
    e.acceptEdge = cycleCount;
    expQ.push_back(e);
  endtask

  task automatic doReset();
    checkEn = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    start = 1'b0;
    expQ.delete();
    heldD = 32'd0;
    @(posedge clk);
    @(negedge clk);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_d", d, 32'd0);
    checkOutput("rst_p_lost", 32'(p_lost), 32'd0);
    checkOutput("rst_invalid", 32'(invalid), 32'd0);
    reset   = 1'b0;
    checkEn = 1'b1;
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (expQ.size() != 0 || busy) begin
      @(negedge clk);
      guard++;
      if (guard > 500) begin
        checkOutput("drain_timeout", 32'd1, 32'd0);
        return;
      end
    end
    repeat (3) @(negedge clk);
  endtask

  // Stimulus sequence.
  initial begin
    exp_t r;
    logic [31:0] vecs[13];
    assertCount = 0;
    failCount   = 0;
    checkEn     = 1'b0;
    heldD       = 32'd0;
    reset       = 1'b1;
    start       = 1'b0;
    a           = 32'd0;

    // Hand-computed expectations pinning the model.
    r = model(32'h3F80_0000);
    checkOutput("model_1p0_d", r.d, 32'h0000_0001);
    checkOutput("model_1p0_lat", 32'(r.lat), 32'd7);
    r = model(32'hC049_0FDB);
    checkOutput("model_pi_d", r.d, 32'hFFFF_FFFD);
    checkOutput("model_pi_pl", 32'(r.pLost), 32'd1);
    r = model(32'h4EFF_FFFF);
    checkOutput("model_e157_d", r.d, 32'h7FFF_FF80);
    r = model(32'h4F00_0000);
    checkOutput("model_big_inv", 32'(r.inv), 32'd1);
    r = model(32'h4B7F_FFFF);
    checkOutput("model_exact_lat", 32'(r.lat), 32'd1);
    r = model(32'h3F00_0000);
    checkOutput("model_half_pl", 32'(r.pLost), 32'd1);

    repeat (2) @(posedge clk);
    doReset();

    vecs = '{32'h3F80_0000, 32'hC049_0FDB, 32'h4B7F_FFFF, 32'h4EFF_FFFF,
             32'hCF00_0000, 32'h4F00_0000, 32'h7FC0_0000, 32'hFF80_0000,
             32'h3F00_0000, 32'h0000_0001, 32'h8000_0000, 32'hCEFF_FFFF,
             32'h4B00_0001};
    foreach (vecs[i]) applyStimulus(vecs[i], 1'b0);
    drain();

    // Start while busy is ignored; operand changes while busy have no effect.
    applyStimulus(32'h3F80_0000, 1'b0);
    @(negedge clk);
    start = 1'b1;
    a     = 32'h4000_0000;
    @(negedge clk);
    start = 1'b0;
    a     = 32'hDEAD_BEEF;
    // Start in the done cycle is accepted.
    applyStimulus(32'h4000_0000, 1'b1);
    drain();
    checkOutput("done_cycle_d", d, 32'h0000_0002);

    // Reset in the middle of a shift aborts with no done pulse.
    applyStimulus(32'h3F80_0000, 1'b0);
    @(negedge clk);
    doReset();
    repeat (10) @(negedge clk);
    applyStimulus(32'h4120_0000, 1'b0);
    drain();
    checkOutput("after_rst_d", d, 32'h0000_000A);

    checkEn = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
